// File: rtl/crc16_decode.sv
// USB DATA packet receiver: deserialises PID+payload and checks the CRC16 residual.
// Delivers {data,pid} with a one-cycle pass or fail verdict.
module crc16_decode #(
   parameter int          PID_LEN  = 8,
   parameter int          DATA_LEN = 64,
   parameter int          CRC_LEN  = 16,
   parameter logic [15:0] RESIDUAL = 16'h800D
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        rx_start,
   input  logic                        bit_in,
   input  logic                        bit_valid,
   input  logic                        rx_abort,
   output logic [PID_LEN+DATA_LEN-1:0] pkt_out,
   output logic                        pkt_valid,
   output logic                        crc_error,
   output logic                        busy
);

   localparam int PKT_LEN = PID_LEN + DATA_LEN;

   localparam logic [6:0] PID_LAST  = 7'(PID_LEN - 1);
   localparam logic [6:0] DATA_LAST = 7'(PKT_LEN - 1);
   localparam logic [6:0] CRC_LAST  = 7'(PKT_LEN + CRC_LEN - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PID   = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_CRC   = 3'd3;
   localparam logic [2:0] S_CHECK = 3'd4;

   logic [2:0]  state;
   logic [6:0]  bit_cnt;
   logic [15:0] lfsr;

   // x^16 + x^15 + x^2 + 1, state ordered {x15..x0}
   function automatic logic [15:0] lfsr_step(
      input logic [15:0] s,
      input logic        b
   );
      logic fb;
      fb = b ^ s[15];
      return {s[14] ^ fb, s[13:2], s[1] ^ fb, s[0], fb};
   endfunction

   assign busy = (state != S_IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         lfsr      <= 16'hFFFF;
         pkt_out   <= '0;
         pkt_valid <= 1'b0;
         crc_error <= 1'b0;
      end else begin
         pkt_valid <= 1'b0;
         crc_error <= 1'b0;
         // a restart in CHECK still delivers the verdict; a bare abort drops it
         if (state == S_CHECK && (rx_start || !rx_abort)) begin
            pkt_valid <= (lfsr == RESIDUAL);
            crc_error <= (lfsr != RESIDUAL);
         end
         if (rx_start) begin
            state   <= S_PID;
            bit_cnt <= '0;
            lfsr    <= 16'hFFFF;
         end else if (rx_abort && state != S_IDLE) begin
            state <= S_IDLE;
         end else begin
            unique case (state)
               S_IDLE: begin
               end
               S_PID: begin
                  if (bit_valid) begin
                     pkt_out <= {bit_in, pkt_out[PKT_LEN-1:1]};
                     bit_cnt <= bit_cnt + 7'd1;
                     if (bit_cnt == PID_LAST)
                        state <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (bit_valid) begin
                     pkt_out <= {bit_in, pkt_out[PKT_LEN-1:1]};
                     lfsr    <= lfsr_step(lfsr, bit_in);
                     bit_cnt <= bit_cnt + 7'd1;
                     if (bit_cnt == DATA_LAST)
                        state <= S_CRC;
                  end
               end
               S_CRC: begin
                  if (bit_valid) begin
                     lfsr    <= lfsr_step(lfsr, bit_in);
                     bit_cnt <= bit_cnt + 7'd1;
                     if (bit_cnt == CRC_LAST)
                        state <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  state <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_crc16_decode.sv
// Randomised bench for crc16_decode against a packet-level reference model.
// Directed packets pin the model with literal expectations.
module tb_crc16_decode;

   logic        clock = 1'b0;
   logic        reset;
   logic        rx_start;
   logic        bit_in;
   logic        bit_valid;
   logic        rx_abort;
   logic [71:0] pkt_out;
   logic        pkt_valid;
   logic        crc_error;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   crc16_decode dut (
      .clock     (clock),
      .reset     (reset),
      .rx_start  (rx_start),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .rx_abort  (rx_abort),
      .pkt_out   (pkt_out),
      .pkt_valid (pkt_valid),
      .crc_error (crc_error),
      .busy      (busy)
   );

   task automatic check(
      input string       name,
      input logic [71:0] act,
      input logic [71:0] exp
   );
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // USB CRC16 register after the payload, initial value all ones
   function automatic logic [15:0] crc_reg(input logic [63:0] d);
      logic [15:0] r;
      r = 16'hFFFF;
      for (int i = 0; i < 64; i++) begin
         if (d[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   // transmitted field: complemented register, x15 sent first
   function automatic logic [15:0] crc_field(input logic [63:0] d);
      logic [15:0] r;
      logic [15:0] f;
      r = crc_reg(d);
      for (int k = 0; k < 16; k++) f[k] = ~r[15-k];
      return f;
   endfunction

   function automatic logic [87:0] mk(
      input logic [7:0]  pid,
      input logic [63:0] d,
      input int          flip
   );
      logic [87:0] p;
      p = {crc_field(d), d, pid};
      if (flip >= 0) p[flip] = ~p[flip];
      return p;
   endfunction

   // reference model: bit list per packet, verdict from the field itself
   logic [87:0] m_bits = '0;
   int          m_n    = 0;
   bit          m_act  = 1'b0;
   logic        e_pv   = 1'b0;
   logic        e_ce   = 1'b0;
   logic        e_busy = 1'b0;
   logic [71:0] e_pkt  = '0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_act = 1'b0;
         m_n   = 0;
         e_pv  = 1'b0;
         e_ce  = 1'b0;
         e_pkt = '0;
      end else begin
         e_pv = 1'b0;
         e_ce = 1'b0;
         if (m_act && m_n == 88 && (rx_start || !rx_abort)) begin
            if (m_bits[87:72] == crc_field(m_bits[71:8])) begin
               e_pv  = 1'b1;
               e_pkt = m_bits[71:0];
            end else begin
               e_ce = 1'b1;
            end
         end
         if (rx_start) begin
            m_act = 1'b1;
            m_n   = 0;
         end else if (m_act && rx_abort) begin
            m_act = 1'b0;
         end else if (m_act && m_n == 88) begin
            m_act = 1'b0;
         end else if (m_act && bit_valid) begin
            m_bits[m_n] = bit_in;
            m_n++;
         end
      end
      e_busy = m_act;
   end

   bit          chk_en     = 1'b0;
   bit          track_busy = 1'b0;
   int          busy_lows  = 0;
   int          pv_cnt     = 0;
   int          ce_cnt     = 0;
   logic [71:0] last_pkt   = '0;

   always @(negedge clock) begin
      if (chk_en) begin
         check("pkt_valid", 72'(pkt_valid), 72'(e_pv));
         check("crc_error", 72'(crc_error), 72'(e_ce));
         check("busy", 72'(busy), 72'(e_busy));
         if (e_pv) check("pkt_out", pkt_out, e_pkt);
         if (reset) check("pkt_out_reset", pkt_out, 72'h0);
         if (pkt_valid) begin
            pv_cnt++;
            last_pkt = pkt_out;
         end
         if (crc_error) ce_cnt++;
         if (track_busy && !busy) busy_lows++;
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick;
   endtask

   task automatic start;
      rx_start = 1'b1;
      tick;
      rx_start = 1'b0;
   endtask

   // mode 0: back-to-back, 1: fixed stall pattern, 2: random stalls
   task automatic send(
      input logic [87:0] p,
      input int          nbits,
      input int          mode
   );
      for (int i = 0; i < nbits; i++) begin
         int g;
         g = 0;
         if (mode == 1) begin
            if (i > 0 && i % 5 == 0) g = 3;
            if (i == 80) g += 20;
         end else if (mode == 2) begin
            if ($urandom_range(0, 3) == 0) g = $urandom_range(1, 4);
         end
         bit_valid = 1'b0;
         repeat (g) begin
            bit_in = 1'($urandom_range(0, 1));
            tick;
         end
         bit_valid = 1'b1;
         bit_in    = p[i];
         tick;
      end
      bit_valid = 1'b0;
      bit_in    = 1'b0;
   endtask

   localparam logic [63:0] D1 = 64'h0706050403020100;

   initial begin
      logic [87:0] p1;
      logic [87:0] pa;
      logic [87:0] pb;
      int          pv0;
      int          ce0;

      reset     = 1'b1;
      rx_start  = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      rx_abort  = 1'b0;
      chk_en    = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(2);
      check("reset_pkt_out", pkt_out, 72'h0);
      check("reset_busy", 72'(busy), 72'h0);

      // encoder loopback
      p1  = mk(8'hC3, D1, -1);
      pv0 = pv_cnt;
      ce0 = ce_cnt;
      start;
      send(p1, 88, 0);
      check("c1_no_early_pv", 72'(pkt_valid), 72'h0);
      tick;
      check("c1_pv_timing", 72'(pkt_valid), 72'h1);
      idle(2);
      check("c1_pv_count", 72'(pv_cnt - pv0), 72'h1);
      check("c1_ce_count", 72'(ce_cnt - ce0), 72'h0);
      check("c1_pkt", last_pkt, 72'h0706050403020100C3);

      // data bit 32 inverted
      pv0 = pv_cnt;
      ce0 = ce_cnt;
      start;
      send(mk(8'hC3, D1, 40), 88, 0);
      idle(3);
      check("c2_pv_count", 72'(pv_cnt - pv0), 72'h0);
      check("c2_ce_count", 72'(ce_cnt - ce0), 72'h1);

      // stalls, busy held throughout
      pv0       = pv_cnt;
      busy_lows = 0;
      start;
      track_busy = 1'b1;
      send(p1, 88, 1);
      track_busy = 1'b0;
      idle(3);
      check("c3_busy_lows", 72'(busy_lows), 72'h0);
      check("c3_pv_count", 72'(pv_cnt - pv0), 72'h1);
      check("c3_pkt", last_pkt, 72'h0706050403020100C3);

      // abort mid packet, abort in idle, then a good one
      pv0 = pv_cnt;
      ce0 = ce_cnt;
      start;
      send(p1, 30, 0);
      rx_abort  = 1'b1;
      bit_valid = 1'b1;
      tick;
      bit_valid = 1'b0;
      idle(5);
      rx_abort = 1'b0;
      check("c4_busy_idle", 72'(busy), 72'h0);
      pa = mk(8'h4B, 64'h0123456789ABCDEF, -1);
      start;
      send(pa, 88, 0);
      idle(3);
      check("c4_pv_count", 72'(pv_cnt - pv0), 72'h1);
      check("c4_ce_count", 72'(ce_cnt - ce0), 72'h0);
      check("c4_pkt", last_pkt, 72'h0123456789ABCDEF4B);

      // restart mid packet
      pv0 = pv_cnt;
      pb  = mk(8'hD2, 64'hDEADBEEFCAFEF00D, -1);
      start;
      send(pa, 50, 0);
      start;
      send(pb, 88, 0);
      idle(3);
      check("c5_pv_count", 72'(pv_cnt - pv0), 72'h1);
      check("c5_pkt", last_pkt, 72'hDEADBEEFCAFEF00DD2);

      // start and abort together: start wins
      pv0 = pv_cnt;
      start;
      send(pa, 20, 0);
      rx_start = 1'b1;
      rx_abort = 1'b1;
      tick;
      rx_start = 1'b0;
      rx_abort = 1'b0;
      send(p1, 88, 0);
      idle(3);
      check("c5b_pv_count", 72'(pv_cnt - pv0), 72'h1);

      // reset mid packet, then all-ones payload
      pv0 = pv_cnt;
      start;
      send(p1, 60, 0);
      reset = 1'b1;
      #1;
      check("c6_async_busy", 72'(busy), 72'h0);
      check("c6_async_pkt", pkt_out, 72'h0);
      idle(2);
      reset = 1'b0;
      idle(1);
      start;
      send(mk(8'hC3, 64'hFFFF_FFFF_FFFF_FFFF, -1), 88, 0);
      idle(3);
      check("c6_pv_count", 72'(pv_cnt - pv0), 72'h1);
      check("c6_pkt", last_pkt, 72'hFFFFFFFFFFFFFFFFC3);

      // random traffic
      for (int it = 0; it < 60; it++) begin
         logic [63:0] d;
         logic [87:0] p;
         int          flip;
         int          act;
         d    = {$urandom, $urandom};
         flip = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 87) : -1;
         p    = mk(8'($urandom), d, flip);
         act  = $urandom_range(0, 9);
         start;
         if (act == 0) begin
            send(p, $urandom_range(1, 87), 2);
            rx_abort  = 1'b1;
            bit_valid = 1'($urandom_range(0, 1));
            bit_in    = 1'($urandom_range(0, 1));
            tick;
            rx_abort  = 1'b0;
            bit_valid = 1'b0;
         end else if (act == 1) begin
            send(p, $urandom_range(1, 87), 2);
            start;
            send(mk(8'($urandom), d, -1), 88, 2);
         end else begin
            send(p, 88, 2);
         end
         idle($urandom_range(0, 3));
      end
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
